bsg_nasti_sr_burst_gen: RTL

BSG_NASTI_SR_BURST_GEN -- requirements
Module: bsg_nasti_sr_burst_gen

---
 rtl/bsg_nasti_sr_burst_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bsg_nasti_sr_burst_gen.sv
// ---------------------------------------------------------------------------
// bsg_nasti_sr_burst_gen
//
// Purpose:
//   Turns one NASTI-style INCR read-burst request into a sequence of single
//   beat memory reads. Each returned beat is packed as {last, id, data} and
//   handed toward a serializing tunnel with valid/yumi handshaking. Only one
//   memory read is ever outstanding; a beat must be consumed before the next
//   address is issued.
//
// Ports:
//   clk_i, reset_i          single clock, synchronous active-high reset
//   ar_valid_i/ar_ready_o   burst request handshake (id, byte addr, len-1)
//   ar_id_i, ar_addr_i, ar_len_i
//   mem_v_o/mem_ready_i     per-beat memory read command, address mem_addr_o
//   mem_data_v_i, mem_data_i  memory read return, no backpressure
//   resp_valid_o/resp_yumi_i  response packet handshake, resp_data_o
//   burst_cnt_o             (optional) count of completed bursts
//
// Configuration:
//   Define BSG_NASTI_SR_BURST_CNT_EN to add the 32-bit burst_cnt_o output,
//   which counts last-beat consumptions and wraps at 2^32.
// ---------------------------------------------------------------------------
module bsg_nasti_sr_burst_gen #(
    parameter int data_width_p = 64,
    parameter int id_width_p   = 5,
    parameter int addr_width_p = 32,
    parameter int len_width_p  = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,

    input  logic                                 ar_valid_i,
    input  logic [id_width_p-1:0]                ar_id_i,
    input  logic [addr_width_p-1:0]              ar_addr_i,
    input  logic [len_width_p-1:0]               ar_len_i,
    output logic                                 ar_ready_o,

    output logic                                 mem_v_o,
    output logic [addr_width_p-1:0]              mem_addr_o,
    input  logic                                 mem_ready_i,

    input  logic                                 mem_data_v_i,
    input  logic [data_width_p-1:0]              mem_data_i,

`ifdef BSG_NASTI_SR_BURST_CNT_EN
    output logic [31:0]                          burst_cnt_o,
`endif

    output logic                                 resp_valid_o,
    output logic [id_width_p+data_width_p:0]     resp_data_o,
    input  logic                                 resp_yumi_i
);

    localparam int pkt_width_lp = 1 + id_width_p + data_width_p;
    localparam logic [addr_width_p-1:0] beat_bytes_lp = addr_width_p'(data_width_p / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } state_e;

    state_e                    r_state;
    logic [id_width_p-1:0]     r_id;
    logic [addr_width_p-1:0]   r_addr;
    logic [len_width_p-1:0]    r_len;
    logic [len_width_p-1:0]    r_beat;
    logic                      r_ar_ready;
    logic                      r_mem_v;
    logic                      r_resp_valid;
    logic [pkt_width_lp-1:0]   r_resp_data;

    // The held packet's MSB is the last flag computed at capture time.
    logic                      w_last;
    assign w_last = r_resp_data[pkt_width_lp-1];

    // Burst sequencing FSM; all handshake outputs are registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_beat       <= '0;
            r_ar_ready   <= 1'b1;
            r_mem_v      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ar_valid_i) begin
                        r_id       <= ar_id_i;
                        r_addr     <= ar_addr_i;
                        r_len      <= ar_len_i;
                        r_beat     <= '0;
                        r_ar_ready <= 1'b0;
                        r_mem_v    <= 1'b1;
                        r_state    <= ISSUE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (mem_ready_i) begin
                        r_mem_v <= 1'b0;
                        r_state <= WAIT;
                    end else begin
                        r_state <= ISSUE;
                    end
                end
                WAIT: begin
                    // Only a return in WAIT is accepted; strays elsewhere are dropped.
                    if (mem_data_v_i) begin
                        r_resp_data  <= {(r_beat == r_len), r_id, mem_data_i};
                        r_resp_valid <= 1'b1;
                        r_state      <= SEND;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                SEND: begin
                    if (resp_yumi_i) begin
                        r_resp_valid <= 1'b0;
                        if (w_last) begin
                            r_ar_ready <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            // INCR burst: address wraps silently at the top of the space.
                            r_beat  <= r_beat + len_width_p'(1);
                            r_addr  <= r_addr + beat_bytes_lp;
                            r_mem_v <= 1'b1;
                            r_state <= ISSUE;
                        end
                    end else begin
                        r_state <= SEND;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_ar_ready   <= 1'b1;
                    r_mem_v      <= 1'b0;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BSG_NASTI_SR_BURST_CNT_EN
    logic [31:0] r_burst_cnt;

    // Counts bursts whose last beat has been consumed downstream.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_burst_cnt <= 32'd0;
        end else if ((r_state == SEND) && resp_yumi_i && w_last) begin
            r_burst_cnt <= r_burst_cnt + 32'd1;
        end else begin
            r_burst_cnt <= r_burst_cnt;
        end
    end

    assign burst_cnt_o = r_burst_cnt;
`endif

    assign ar_ready_o   = r_ar_ready;
    assign mem_v_o      = r_mem_v;
    assign mem_addr_o   = r_addr;
    assign resp_valid_o = r_resp_valid;
    assign resp_data_o  = r_resp_data;

endmodule
